// File: rtl/lfsr_seq_checker.sv
// rtl/lfsr_seq_checker.sv - Fibonacci LFSR stream checker: lock, error count, stuck detect, period
//
// Ports:
//   clk          in   1      clock, rising edge
//   rst          in   1      asynchronous active-low reset
//   data_in      in   WIDTH  LFSR word from the upstream stage
//   data_valid   in   1      data_in carries a new sample this cycle
//   clear        in   1      synchronous soft clear of all state and statistics
//   locked       out  1      checker is tracking the sequence
//   err_pulse    out  1      one-cycle pulse per misprediction while locked
//   err_count    out  CNT_W  mispredictions while locked, saturating
//   period       out  CNT_W  last measured sequence period in samples
//   period_valid out  1      period holds a measured value (sticky)
//   stuck        out  1      an all-zero sample was received
module lfsr_seq_checker #(
  parameter int              WIDTH    = 5,
  parameter logic [WIDTH-1:0] TAPS    = 5'b10100,
  parameter int              LOCK_CNT = 4,
  parameter int              LOSS_CNT = 3,
  parameter int              CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             stuck
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int LW = $clog2(LOSS_CNT + 1);

  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED, STUCK} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] expected, expected_nxt;
  logic [WIDTH-1:0] anchor, anchor_nxt;
  logic [MW-1:0]    match, match_nxt, match_inc;
  logic [LW-1:0]    miss, miss_nxt, miss_inc;
  logic [CNT_W-1:0] samp_cnt, samp_cnt_nxt;
  logic [CNT_W-1:0] err_count_nxt, period_nxt;
  logic             locked_nxt, err_pulse_nxt, period_valid_nxt, stuck_nxt;

  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] cur);
    step = {cur[WIDTH-2:0], ^(cur & TAPS)};
  endfunction

  assign match_inc = match + MW'(1);
  assign miss_inc  = miss + LW'(1);

  always_comb begin
    state_nxt        = state;
    expected_nxt     = expected;
    anchor_nxt       = anchor;
    match_nxt        = match;
    miss_nxt         = miss;
    samp_cnt_nxt     = samp_cnt;
    err_count_nxt    = err_count;
    period_nxt       = period;
    locked_nxt       = locked;
    period_valid_nxt = period_valid;
    stuck_nxt        = stuck;
    err_pulse_nxt    = 1'b0;  // pulse lasts one cycle whether or not a sample follows

    if (clear) begin
      state_nxt        = IDLE;
      expected_nxt     = '0;
      anchor_nxt       = '0;
      match_nxt        = '0;
      miss_nxt         = '0;
      samp_cnt_nxt     = '0;
      err_count_nxt    = '0;
      period_nxt       = '0;
      locked_nxt       = 1'b0;
      period_valid_nxt = 1'b0;
      stuck_nxt        = 1'b0;
    end else if (data_valid) begin
      if (data_in == '0) begin
        // All-zero is the LFSR lock-up state; it overrides every other state.
        state_nxt  = STUCK;
        stuck_nxt  = 1'b1;
        locked_nxt = 1'b0;
        match_nxt  = '0;
        miss_nxt   = '0;
      end else begin
        unique case (state)
          IDLE, STUCK: begin
            state_nxt    = ACQUIRE;
            stuck_nxt    = 1'b0;
            expected_nxt = step(data_in);
            match_nxt    = '0;
          end
          ACQUIRE: begin
            expected_nxt = step(data_in);
            if (data_in == expected) begin
              match_nxt = match_inc;
              if (match_inc == MW'(LOCK_CNT)) begin
                state_nxt    = LOCKED;
                locked_nxt   = 1'b1;
                anchor_nxt   = data_in;
                samp_cnt_nxt = '0;
                miss_nxt     = '0;
              end
            end else begin
              match_nxt = '0;
            end
          end
          LOCKED: begin
            // Free-running prediction: a single corrupted sample costs one error.
            expected_nxt = step(expected);
            if (data_in == anchor) begin
              period_nxt       = samp_cnt + CNT_W'(1);
              period_valid_nxt = 1'b1;
              samp_cnt_nxt     = '0;
            end else if (samp_cnt != '1) begin
              samp_cnt_nxt = samp_cnt + CNT_W'(1);
            end
            if (data_in == expected) begin
              miss_nxt = '0;
            end else begin
              err_pulse_nxt = 1'b1;
              if (err_count != '1) begin
                err_count_nxt = err_count + CNT_W'(1);
              end
              miss_nxt = miss_inc;
              if (miss_inc == LW'(LOSS_CNT)) begin
                // Resync: restart acquisition from the incoming sample.
                state_nxt    = ACQUIRE;
                locked_nxt   = 1'b0;
                match_nxt    = '0;
                miss_nxt     = '0;
                expected_nxt = step(data_in);
              end
            end
          end
          default: state_nxt = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      expected     <= '0;
      anchor       <= '0;
      match        <= '0;
      miss         <= '0;
      samp_cnt     <= '0;
      err_count    <= '0;
      period       <= '0;
      locked       <= 1'b0;
      err_pulse    <= 1'b0;
      period_valid <= 1'b0;
      stuck        <= 1'b0;
    end else begin
      state        <= state_nxt;
      expected     <= expected_nxt;
      anchor       <= anchor_nxt;
      match        <= match_nxt;
      miss         <= miss_nxt;
      samp_cnt     <= samp_cnt_nxt;
      err_count    <= err_count_nxt;
      period       <= period_nxt;
      locked       <= locked_nxt;
      err_pulse    <= err_pulse_nxt;
      period_valid <= period_valid_nxt;
      stuck        <= stuck_nxt;
    end
  end

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// tb/tb_lfsr_seq_checker.sv - scoreboard testbench for lfsr_seq_checker
module tb_lfsr_seq_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  data_in = '0;
  logic        data_valid = 1'b0;
  logic        clear = 1'b0;
  logic        locked, err_pulse, period_valid, stuck;
  logic [15:0] err_count, period;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;
    logic [15:0] period;
    logic        period_valid;
    logic        stuck;
    string       name;
  } exp_t;

  exp_t       exp_q[$];
  logic [4:0] seq[0:99];

  lfsr_seq_checker dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid), .clear(clear),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count), .period(period),
    .period_valid(period_valid), .stuck(stuck)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic l, input logic ep, input int ec, input int per,
                              input logic pv, input logic st, input string nm);
    exp_t e;
    e.locked = l; e.err_pulse = ep; e.err_count = 16'(ec); e.period = 16'(per);
    e.period_valid = pv; e.stuck = st; e.name = nm;
    return e;
  endfunction

  // Monitor: every clock edge that samples valid data or clear produces one response.
  always @(posedge clk) begin
    if (rst && (data_valid || clear)) begin
      #1;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL scoreboard_underflow: DUT produced a response with no expected entry");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (locked !== e.locked || err_pulse !== e.err_pulse || err_count !== e.err_count ||
            period !== e.period || period_valid !== e.period_valid || stuck !== e.stuck) begin
          fails++;
          $display("FAIL %s: got locked=%0b err_pulse=%0b err_count=%0d period=%0d pv=%0b stuck=%0b, want %0b %0b %0d %0d %0b %0b",
                   e.name, locked, err_pulse, err_count, period, period_valid, stuck,
                   e.locked, e.err_pulse, e.err_count, e.period, e.period_valid, e.stuck);
        end
      end
    end
  end

  task automatic send(input logic [4:0] d, input logic v, input logic c, input exp_t e);
    @(negedge clk);
    data_in = d; data_valid = v; clear = c;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    data_valid = 1'b0; clear = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0d want %0d", nm, act, want);
    end
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, "_locked"}, 32'(locked), 0);
    check({nm, "_err_pulse"}, 32'(err_pulse), 0);
    check({nm, "_err_count"}, 32'(err_count), 0);
    check({nm, "_period"}, 32'(period), 0);
    check({nm, "_period_valid"}, 32'(period_valid), 0);
    check({nm, "_stuck"}, 32'(stuck), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    seq[0] = 5'b00111;
    for (int i = 1; i < 100; i++) seq[i] = {seq[i-1][3:0], seq[i-1][4] ^ seq[i-1][2]};

    // 1: reset, then idle
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("idle_after_reset");

    // 2: acquire; lock on the 5th sample
    for (int i = 0; i <= 4; i++) send(seq[i], 1, 0, mk(i == 4, 0, 0, 0, 0, 0, "acquire"));

    // 3: 40 more samples; anchor seq[4] recurs at seq[35]
    for (int i = 5; i <= 44; i++)
      send(seq[i], 1, 0, mk(1, 0, 0, (i >= 35) ? 31 : 0, i >= 35, 0, "period"));

    // 4: one corrupted sample
    send(seq[45] ^ 5'b00001, 1, 0, mk(1, 1, 1, 31, 1, 0, "corrupt_one"));
    idle(1);
    @(negedge clk);
    check("pulse_single_cycle", 32'(err_pulse), 0);
    check("idle_keeps_err_count", 32'(err_count), 1);
    check("idle_keeps_locked", 32'(locked), 1);
    for (int i = 46; i <= 50; i++) send(seq[i], 1, 0, mk(1, 0, 1, 31, 1, 0, "resume"));

    // soft clear, then relock
    send(5'b00000, 0, 1, mk(0, 0, 0, 0, 0, 0, "clear_only"));
    for (int i = 51; i <= 55; i++) send(seq[i], 1, 0, mk(i == 55, 0, 0, 0, 0, 0, "relock"));
    for (int i = 56; i <= 58; i++) send(seq[i], 1, 0, mk(1, 0, 0, 0, 0, 0, "locked_run"));

    // 5: slip (seq[59] skipped): three errors, lose lock, relock 4 samples later
    send(seq[60], 1, 0, mk(1, 1, 1, 0, 0, 0, "slip_err1"));
    send(seq[61], 1, 0, mk(1, 1, 2, 0, 0, 0, "slip_err2"));
    send(seq[62], 1, 0, mk(0, 1, 3, 0, 0, 0, "slip_loss"));
    for (int i = 63; i <= 66; i++) send(seq[i], 1, 0, mk(i == 66, 0, 3, 0, 0, 0, "slip_relock"));

    // 6: stuck detect, recovery, stuck again, clear beats data_valid
    send(5'b00000, 1, 0, mk(0, 0, 3, 0, 0, 1, "stuck"));
    send(seq[7], 1, 0, mk(0, 0, 3, 0, 0, 0, "stuck_recover"));
    send(5'b00000, 1, 0, mk(0, 0, 3, 0, 0, 1, "stuck_again"));
    send(seq[0], 1, 1, mk(0, 0, 0, 0, 0, 0, "clear_with_valid"));
    // seq[0] must have been ignored: lock needs five samples starting at seq[1]
    for (int i = 1; i <= 5; i++) send(seq[i], 1, 0, mk(i == 5, 0, 0, 0, 0, 0, "after_clear"));
    send(seq[6] ^ 5'b00001, 1, 0, mk(1, 1, 1, 0, 0, 0, "pre_reset_err"));
    idle(2);

    // async reset in mid-cycle
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(negedge clk);
    rst = 1'b1;

    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
